instr_fetch_unit: RTL and testbench

- Front end of the processor: owns the program counter, fetches 16-bit instruction words from instruction memory over a req/ack handshake, and issues them to control_unit.
- Presents each word as ir_data, qualified by a one-cycle ir_valid pulse.
- Resolves jump, conditional jump and halt opcodes locally, using the cy/zero flags that control_unit also consumes, so branches never reach the datapath.

---
 rtl/cpu_defs_pkg.sv | 29 ++
 rtl/branch_resolve.sv | 70 +++++++
 rtl/instr_fetch_unit.sv | 109 ++++++++++
 tb/tb_instr_fetch_unit.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the instruction front end and control_unit.
// Holds the opcode constants for the locally resolved control-flow
// instructions, the instruction field positions and the fetch FSM encoding.
package cpu_defs_pkg;

  // Instruction field positions (16-bit instruction word)
  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int TGT_MSB = 7;
  localparam int TGT_LSB = 0;

  // Opcodes handled inside the fetch unit; everything else is datapath work
  localparam logic [3:0] OP_JMP  = 4'hC;
  localparam logic [3:0] OP_JC   = 4'hD;
  localparam logic [3:0] OP_JZ   = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_EXEC   = 2'd2,
    ST_HALTED = 2'd3
  } fetch_state_t;

  function automatic logic [3:0] opcode_of(input logic [15:0] ir);
    return ir[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/branch_resolve.sv
// Combinational control-flow resolution for the instruction in ir.
// Ports:
//   ir       in   instruction register contents
//   pc       in   address of the instruction in ir
//   cy,zero  in   ALU flags used by JC / JZ
//   next_pc  out  pc to load at the end of EXEC
//   is_ctrl  out  instruction is JMP/JC/JZ/HALT (not forwarded to the datapath)
//   is_halt  out  instruction is HALT
module branch_resolve
  import cpu_defs_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] ir,
  input  logic [ADDR_W-1:0] pc,
  input  logic              cy,
  input  logic              zero,
  output logic [ADDR_W-1:0] next_pc,
  output logic              is_ctrl,
  output logic              is_halt
);

  logic [3:0]        opcode;
  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] pc_inc;
  logic              taken;
  logic              unused_ir_bits;

  assign opcode = opcode_of(ir);
  // Absolute target taken straight from the low field, no relative math
  assign target = ir[TGT_LSB +: ADDR_W];
  // Natural wrap modulo 2^ADDR_W
  assign pc_inc = pc + 1'b1;
  // Bits between the target field and the opcode carry no meaning here
  assign unused_ir_bits = &{1'b0, ir};

  always_comb begin
    taken   = 1'b0;
    is_ctrl = 1'b0;
    is_halt = 1'b0;
    case (opcode)
      OP_JMP: begin
        is_ctrl = 1'b1;
        taken   = 1'b1;
      end
      OP_JC: begin
        is_ctrl = 1'b1;
        taken   = cy;
      end
      OP_JZ: begin
        is_ctrl = 1'b1;
        taken   = zero;
      end
      OP_HALT: begin
        is_ctrl = 1'b1;
        is_halt = 1'b1;
      end
      default: ;
    endcase

    if (is_halt)
      next_pc = pc;
    else if (taken)
      next_pc = target;
    else
      next_pc = pc_inc;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Processor front end: owns the pc, fetches instruction words over a
// req/ack handshake, resolves jumps and HALT locally and forwards datapath
// instructions to control_unit with a one-cycle ir_valid pulse.
// Ports:
//   clk, rst            clock, async active-high reset
//   run_en              allow new fetches; low parks in IDLE after the current instruction
//   mem_req/mem_addr    fetch request and address (address is always pc)
//   mem_rdata/mem_ack   returned word, valid when ack is high
//   cy, zero            ALU flags, only looked at in EXEC
//   ir_data/ir_valid    instruction register and its new-instruction pulse
//   pc                  program counter
//   halted              HALT has executed; only rst leaves this state
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | no request; waits for run_en
// FETCH    | mem_req high at pc until mem_ack, then captures the word
// EXEC     | one cycle: pulse ir_valid or resolve jump/halt, update pc
// HALTED   | HALT executed; parked until reset
module instr_fetch_unit
  import cpu_defs_pkg::*;
#(
  parameter int              ADDR_W   = 8,
  parameter int              DATA_W   = 16,   // opcode field assumes 16
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run_en,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  input  logic              cy,
  input  logic              zero,
  output logic [DATA_W-1:0] ir_data,
  output logic              ir_valid,
  output logic [ADDR_W-1:0] pc,
  output logic              halted
);

  fetch_state_t      state;
  fetch_state_t      state_nxt;
  logic [ADDR_W-1:0] next_pc;
  logic              is_ctrl;
  logic              is_halt;

  branch_resolve #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_branch_resolve (
    .ir      (ir_data),
    .pc      (pc),
    .cy      (cy),
    .zero    (zero),
    .next_pc (next_pc),
    .is_ctrl (is_ctrl),
    .is_halt (is_halt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      pc      <= RESET_PC;
      ir_data <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_FETCH && mem_ack)
        ir_data <= mem_rdata;
      if (state == ST_EXEC)
        pc <= next_pc;
    end
  end

  // Outputs decode straight from state so reset drops mem_req without
  // waiting for a clock edge, and acks outside FETCH have no effect.
  always_comb begin
    state_nxt = state;
    mem_req   = 1'b0;
    ir_valid  = 1'b0;
    halted    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (run_en)
          state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        mem_req = 1'b1;
        if (mem_ack)
          state_nxt = ST_EXEC;
      end
      ST_EXEC: begin
        if (is_halt) begin
          state_nxt = ST_HALTED;
        end else begin
          ir_valid  = ~is_ctrl;
          state_nxt = run_en ? ST_FETCH : ST_IDLE;
        end
      end
      ST_HALTED: begin
        halted = 1'b1;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign mem_addr = pc;

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        run_en;
  logic        mem_req;
  logic [7:0]  mem_addr;
  logic [15:0] mem_rdata;
  logic        mem_ack;
  logic        cy;
  logic        zero;
  logic [15:0] ir_data;
  logic        ir_valid;
  logic [7:0]  pc;
  logic        halted;

  logic [15:0] mem [256];
  logic [7:0]  m_pc;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  instr_fetch_unit #(
    .ADDR_W   (8),
    .DATA_W   (16),
    .RESET_PC (8'h00)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .run_en    (run_en),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .cy        (cy),
    .zero      (zero),
    .ir_data   (ir_data),
    .ir_valid  (ir_valid),
    .pc        (pc),
    .halted    (halted)
  );

  // Instruction-level reference: effect of executing word w at address p
  function automatic void ref_exec(input logic [15:0] w, input logic [7:0] p,
                                   input logic c, input logic z,
                                   output logic valid, output logic [7:0] np,
                                   output logic halt);
    valid = 1'b1;
    halt  = 1'b0;
    np    = 8'((int'(p) + 1) % 256);
    case (w[15:12])
      4'hC: begin valid = 1'b0; np = w[7:0]; end
      4'hD: begin valid = 1'b0; if (c) np = w[7:0]; end
      4'hE: begin valid = 1'b0; if (z) np = w[7:0]; end
      4'hF: begin valid = 1'b0; halt = 1'b1; np = p; end
      default: ;
    endcase
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    run_en = 1'b0;
    mem_ack = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_pc = 8'h00;
  endtask

  // From IDLE (at a falling edge): raise run_en, arrive in FETCH
  task automatic start_fetch();
    checks++;
    if (mem_req !== 1'b0) begin
      errors++;
      $display("FAIL idle_req: mem_req=%b expected 0", mem_req);
    end
    run_en = 1'b1;
    @(negedge clk);
  endtask

  // One full fetch+execute with 'delay' wait cycles before the ack.
  task automatic do_instr(input int delay, input logic c, input logic z, input logic run_next);
    logic [15:0] w;
    logic        ev;
    logic        eh;
    logic [7:0]  np;
    logic        exp_req;
    w = mem[m_pc];
    for (int i = 0; i <= delay; i++) begin
      if (i == delay / 2) run_en = run_next;
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== m_pc) begin
        errors++;
        $display("FAIL fetch_req: mem_req=%b mem_addr=%h expected req=1 addr=%h", mem_req, mem_addr, m_pc);
      end
      cy = 1'($urandom);
      zero = 1'($urandom);
      if (i == delay) begin
        mem_ack = 1'b1;
        mem_rdata = w;
      end else begin
        mem_ack = 1'b0;
        mem_rdata = 16'($urandom);
      end
      @(negedge clk);
    end
    mem_ack = 1'b0;
    mem_rdata = 16'($urandom);
    cy = c;
    zero = z;
    ref_exec(w, m_pc, c, z, ev, np, eh);
    checks++;
    if (ir_valid !== ev || ir_data !== w || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL exec: ir_valid=%b ir_data=%h mem_req=%b expected valid=%b data=%h req=0",
               ir_valid, ir_data, mem_req, ev, w);
    end
    @(negedge clk);
    m_pc = np;
    exp_req = run_next && !eh;
    checks++;
    if (pc !== m_pc || ir_valid !== 1'b0 || mem_req !== exp_req || halted !== eh) begin
      errors++;
      $display("FAIL after_exec: pc=%h ir_valid=%b mem_req=%b halted=%b expected pc=%h valid=0 req=%b halted=%b",
               pc, ir_valid, mem_req, halted, m_pc, exp_req, eh);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (pc !== 8'h00 || ir_data !== 16'h0 || ir_valid !== 1'b0 || mem_req !== 1'b0 || halted !== 1'b0) begin
      errors++;
      $display("FAIL reset: pc=%h ir=%h valid=%b req=%b halted=%b expected all 0",
               pc, ir_data, ir_valid, mem_req, halted);
    end
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[0] = 16'h0001;
    mem[1] = 16'h0002;
    mem[2] = 16'h0A0B;
    start_fetch();
    do_instr(0, 1'b0, 1'b0, 1'b1);
    do_instr(0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_branches();
    mem[3]    = 16'hD020;
    mem[8'h20] = 16'hC003;
    mem[4]    = 16'hE010;
    mem[8'h10] = 16'hC0FF;
    mem[8'hFF] = 16'hC005;
    mem[5]    = 16'hC0FF;
    do_instr(0, 1'b0, 1'b0, 1'b1);  // datapath at 2
    do_instr(0, 1'b1, 1'b0, 1'b1);  // JC taken -> 0x20
    do_instr(0, 1'b0, 1'b0, 1'b1);  // JMP 3
    do_instr(0, 1'b0, 1'b1, 1'b1);  // JC not taken -> 4
    do_instr(0, 1'b0, 1'b1, 1'b1);  // JZ taken -> 0x10
    do_instr(0, 1'b1, 1'b1, 1'b1);  // JMP 0xFF
    do_instr(0, 1'b0, 1'b0, 1'b1);  // JMP at 0xFF -> 5
    do_instr(0, 1'b0, 1'b0, 1'b1);  // JMP 0xFF
    mem[8'hFF] = 16'h1234;
    do_instr(0, 1'b0, 1'b0, 1'b1);  // datapath at 0xFF, wraps to 0
    do_instr(0, 1'b0, 1'b0, 1'b0);  // at 0, then park in IDLE
  endtask

  task automatic test_wait_states();
    start_fetch();
    do_instr(3, 1'b0, 1'b0, 1'b0);  // run_en drops mid-wait
    for (int i = 0; i < 5; i++) begin
      mem_ack = 1'b1;
      mem_rdata = 16'hDEAD;
      @(negedge clk);
      checks++;
      if (mem_req !== 1'b0 || ir_data !== 16'h0002 || pc !== m_pc || ir_valid !== 1'b0) begin
        errors++;
        $display("FAIL idle_hold: req=%b ir=%h pc=%h valid=%b expected req=0 ir=0002 pc=%h valid=0",
                 mem_req, ir_data, pc, ir_valid, m_pc);
      end
    end
    mem_ack = 1'b0;
  endtask

  task automatic test_random();
    logic [15:0] w;
    logic        rn;
    do_reset();
    for (int i = 0; i < 256; i++) begin
      w = 16'($urandom);
      if ($urandom_range(0, 3) == 0) w[15:12] = 4'hC + 4'($urandom_range(0, 2));
      else if (w[15:12] == 4'hF) w[15:12] = 4'h0;
      mem[i] = w;
    end
    start_fetch();
    for (int n = 0; n < 150; n++) begin
      rn = ($urandom_range(0, 7) != 0);
      do_instr($urandom_range(0, 3), 1'($urandom), 1'($urandom), rn);
      if (!rn) begin
        mem_ack = 1'($urandom);
        @(negedge clk);
        mem_ack = 1'b0;
        start_fetch();
      end
    end
    run_en = 1'b0;
  endtask

  task automatic test_halt();
    do_reset();
    mem[0]     = 16'hC042;
    mem[8'h42] = 16'hF000;
    start_fetch();
    do_instr(0, 1'b0, 1'b0, 1'b1);
    do_instr(1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      run_en = 1'b1;
      mem_ack = 1'($urandom);
      mem_rdata = 16'($urandom);
      @(negedge clk);
      checks++;
      if (mem_req !== 1'b0 || halted !== 1'b1 || ir_valid !== 1'b0 || pc !== 8'h42) begin
        errors++;
        $display("FAIL halted_hold: req=%b halted=%b valid=%b pc=%h expected req=0 halted=1 valid=0 pc=42",
                 mem_req, halted, ir_valid, pc);
      end
    end
    mem_ack = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if (pc !== 8'h00 || halted !== 1'b0) begin
      errors++;
      $display("FAIL halt_reset: pc=%h halted=%b expected pc=00 halted=0", pc, halted);
    end
    @(negedge clk);
    rst = 1'b0;
    run_en = 1'b0;
    m_pc = 8'h00;
  endtask

  task automatic test_reset_inflight();
    do_reset();
    mem[0] = 16'h3C3C;
    mem[1] = 16'h0777;
    start_fetch();
    do_instr(0, 1'b0, 1'b0, 1'b1);  // ir_data now 3C3C, fetching at 1
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (mem_req !== 1'b0 || pc !== 8'h00 || ir_data !== 16'h0) begin
      errors++;
      $display("FAIL async_reset: req=%b pc=%h ir=%h expected req=0 pc=00 ir=0000", mem_req, pc, ir_data);
    end
    @(negedge clk);
    rst = 1'b0;
    run_en = 1'b0;
    mem_ack = 1'b1;
    mem_rdata = 16'hBEEF;
    @(negedge clk);
    mem_ack = 1'b0;
    checks++;
    if (ir_data !== 16'h0 || mem_req !== 1'b0 || ir_valid !== 1'b0 || pc !== 8'h00) begin
      errors++;
      $display("FAIL late_ack: ir=%h req=%b valid=%b pc=%h expected ir=0000 req=0 valid=0 pc=00",
               ir_data, mem_req, ir_valid, pc);
    end
    m_pc = 8'h00;
    start_fetch();
    do_instr(0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    run_en = 1'b0;
    mem_ack = 1'b0;
    mem_rdata = 16'h0;
    cy = 1'b0;
    zero = 1'b0;
    m_pc = 8'h00;
    @(negedge clk);
    test_reset();
    test_sequential();
    test_branches();
    test_wait_states();
    test_random();
    test_halt();
    test_reset_inflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
